trigger_capture_buffer: RTL
===========================

Name: trigger_capture_buffer

Overview:
- Single-clock, parametrised successor to the ADC capture store.
- Continuously records multi-lane ADC words into a circular buffer while armed.
- Freezes a window of PRETRIG words before and DEPTH-PRETRIG words from the trigger onward.
- Serialises the window lane by lane onto a SAMPLE_W-wide first-word-fall-through stream that feeds the UART TX wrapper (DataReady / ReadEnable handshake).

Parameters:
- LANES, 4: ADC samples per input word.
- SAMPLE_W, 8: bits per sample; also the DataOut width.
- DEPTH, 256: buffer depth in words. Power of two, at least 4.
- PRETRIG, 16: words kept before the trigger. Range 0 to DEPTH-1.

Ports:
- Clock  in  1  system clock; all logic on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- DataIn  in  LANES*SAMPLE_W  ADC word; lane k = bits [k*SAMPLE_W +: SAMPLE_W].
- DataInValid  in  1  DataIn is valid this cycle.
- FastTrigger  in  1  trigger, level-sampled each cycle.
- Arm  in  1  one-cycle request to start a capture.
- ReadEnable  in  1  consumer takes the current DataOut.
- DataOut  out  SAMPLE_W  current sample.
- DataReady  out  1  DataOut valid.
- Busy  out  1  high in any state other than IDLE.
- Triggered  out  1  high from trigger acceptance until readout completes.
- TrigIgnored  out  1  one-cycle pulse when a trigger arrives in ARMED before pre-fill completes.
- Done  out  1  one-cycle pulse after the last sample is consumed.

Behaviour:
- Reset (asynchronous, Reset=0):
  - State = IDLE.
  - Write pointer, read pointer, fill count, post count, lane index = 0.
  - All outputs 0.
  - Buffer contents are don't-care.
- States: IDLE, ARMED, POST, READOUT.
- IDLE:
  - Arm=1 -> ARMED next cycle; fill count cleared.
  - FastTrigger is ignored. No pulse.
- ARMED:
  - Each cycle with DataInValid=1: write DataIn at wr_ptr, wr_ptr = wr_ptr+1 mod DEPTH, fill count saturates at PRETRIG.
  - Trigger is accepted when FastTrigger=1, DataInValid=1 and fill count == PRETRIG, counting writes before this cycle.
  - On acceptance:
    - The current word is written as the first post word.
    - start = wr_ptr - PRETRIG mod DEPTH, using wr_ptr before the increment.
    - post count = 1, Triggered=1.
    - If DEPTH-PRETRIG == 1 -> READOUT, else -> POST.
  - FastTrigger=1 with fill count < PRETRIG: TrigIgnored pulses; no state change.
  - FastTrigger=1 with DataInValid=0: ignored, no pulse.
  - PRETRIG=0: the first valid trigger is accepted immediately.
- POST:
  - Each valid word is written and post count increments.
  - When post count reaches DEPTH-PRETRIG -> READOUT.
  - FastTrigger and Arm are ignored.
- READOUT:
  - rd_ptr = start, lane = 0.
  - Buffer read is registered. DataReady rises 2 cycles after entering READOUT.
  - DataOut = lane `lane` of word rd_ptr.
  - ReadEnable while DataReady=1 consumes the sample.
    - If lane < LANES-1: next lane is presented the next cycle, DataReady stays 1.
    - If lane == LANES-1: rd_ptr increments mod DEPTH and lane = 0. DataReady is 0 for exactly one cycle, then the next word's lane 0 is presented.
  - ReadEnable while DataReady=0 is ignored.
  - DataOut holds steady while DataReady=1 and ReadEnable=0.
  - After DEPTH*LANES samples are consumed:
    - DataReady=0 and Done pulses on the following cycle.
    - Triggered=0, Busy=0, state -> IDLE.
  - Arm, FastTrigger and DataIn are ignored throughout READOUT; no writes occur.
- Sample order: oldest pre-trigger word first, lane 0 first. The trigger word is word index PRETRIG of the stream.
- Pointer wrap: all pointer arithmetic is modulo DEPTH. The window crossing address DEPTH-1 -> 0 is seamless.
- Simultaneous events:
  - Arm together with FastTrigger in IDLE: arm only.
  - Reset asserted mid-capture or mid-readout: immediate return to reset state, no Done pulse.
- Busy = (state != IDLE).

Test Plan:
- Ramp, basic capture:
  - Stimulus: LANES=4, DEPTH=16, PRETRIG=4. All lanes carry ramp r (0,1,2…) with DataInValid=1. Arm at r=0, trigger at r=20. Consumer holds ReadEnable=1.
  - Response: 64 samples, each value repeated 4 times, in order 16,17,…,31. Done pulses once; Busy falls on the same cycle.
- Early trigger:
  - Stimulus: FastTrigger after only 2 valid words with PRETRIG=4.
  - Response: TrigIgnored=1 for one cycle, state stays ARMED. A later trigger at r=10 yields first sample 6.
- Lane order and wrap:
  - Stimulus: DataIn = {r+3, r+2, r+1, r} (lane 0 = r), DEPTH=16, trigger at r=13.
  - Response: stream starts 9,10,11,12, then 10,11,12,13, … and crosses buffer address 15 -> 0 with no gap or duplicate.
- Handshake throttling:
  - Stimulus: ReadEnable toggled 1-0-1 randomly; DataInValid gaps during POST.
  - Response: no sample lost or repeated; words not written during invalid cycles; exactly one DataReady-low cycle per word boundary.
- Reset mid-readout:
  - Stimulus: drive Reset=0 after 10 samples are consumed.
  - Response: DataReady=0, Busy=0 and Triggered=0 immediately; no Done pulse. A fresh Arm/trigger capture completes normally.
- PRETRIG=0:
  - Stimulus: trigger on the first valid word r=5.
  - Response: first sample is 5 and the stream length is DEPTH*LANES.

Source files
------------

// File: rtl/trigger_capture_buffer.sv
// Circular pre/post-trigger capture of LANES-wide ADC words, replayed lane by lane on a FWFT stream.
// First sample 2 cycles into readout, one DataReady-low cycle per word boundary; ReadEnable throttles the stream.
module trigger_capture_buffer #(
  parameter int LANES    = 4,
  parameter int SAMPLE_W = 8,
  parameter int DEPTH    = 256,
  parameter int PRETRIG  = 16
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic [LANES*SAMPLE_W-1:0] DataIn,
  input  logic                      DataInValid,
  input  logic                      FastTrigger,
  input  logic                      Arm,
  input  logic                      ReadEnable,
  output logic [SAMPLE_W-1:0]       DataOut,
  output logic                      DataReady,
  output logic                      Busy,
  output logic                      Triggered,
  output logic                      TrigIgnored,
  output logic                      Done
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [AW-1:0] PreTrig  = AW'(PRETRIG);
  localparam logic [PW-1:0] PostLen  = PW'(DEPTH - PRETRIG);
  localparam logic [LW-1:0] LastLane = LW'(LANES - 1);

  typedef enum logic [1:0] {IDLE, ARMED, POST, READOUT} stateT;
  typedef enum logic [1:0] {RD_SETUP, RD_LOAD, RD_SHOW} rdPhaseT;

  logic [LANES-1:0][SAMPLE_W-1:0] mem [DEPTH];
  logic [LANES-1:0][SAMPLE_W-1:0] rdWord;
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [AW-1:0] startPtr;
  logic [AW-1:0] fillCnt;
  logic [PW-1:0] postCnt;
  logic [LW-1:0] lane;
  stateT         state;
  rdPhaseT       rdPhase;
  logic          writeEn;

  assign writeEn = DataInValid && ((state == ARMED) || (state == POST));
  assign Busy    = (state != IDLE);
  assign DataOut = rdWord[lane];

  always_ff @(posedge Clock) begin
    if (writeEn) mem[wrPtr] <= DataIn;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state       <= IDLE;
      rdPhase     <= RD_SETUP;
      wrPtr       <= '0;
      rdPtr       <= '0;
      startPtr    <= '0;
      fillCnt     <= '0;
      postCnt     <= '0;
      lane        <= '0;
      rdWord      <= '0;
      DataReady   <= 1'b0;
      Triggered   <= 1'b0;
      TrigIgnored <= 1'b0;
      Done        <= 1'b0;
    end else begin
      TrigIgnored <= 1'b0;
      Done        <= 1'b0;
      if (writeEn) wrPtr <= wrPtr + 1'b1;
      case (state)
        IDLE: begin
          if (Arm) begin
            state   <= ARMED;
            fillCnt <= '0;
          end
        end
        ARMED: begin
          // fillCnt saturates at PRETRIG, so equality means the pre-window is full
          if (DataInValid) begin
            if (FastTrigger && (fillCnt == PreTrig)) begin
              startPtr  <= wrPtr - PreTrig;
              postCnt   <= PW'(1);
              Triggered <= 1'b1;
              rdPhase   <= RD_SETUP;
              state     <= (PostLen == PW'(1)) ? READOUT : POST;
            end else begin
              if (fillCnt != PreTrig) fillCnt <= fillCnt + 1'b1;
              TrigIgnored <= FastTrigger;
            end
          end
        end
        POST: begin
          if (DataInValid) begin
            postCnt <= postCnt + 1'b1;
            if (postCnt + 1'b1 == PostLen) begin
              state   <= READOUT;
              rdPhase <= RD_SETUP;
            end
          end
        end
        READOUT: begin
          case (rdPhase)
            RD_SETUP: begin
              rdPtr   <= startPtr;
              lane    <= '0;
              rdPhase <= RD_LOAD;
            end
            RD_LOAD: begin
              rdWord    <= mem[rdPtr];
              DataReady <= 1'b1;
              rdPhase   <= RD_SHOW;
            end
            default: begin
              if (ReadEnable) begin
                if (lane != LastLane) begin
                  lane <= lane + 1'b1;
                end else begin
                  lane      <= '0;
                  DataReady <= 1'b0;
                  // the window is exactly DEPTH words, so the last one sits just below start
                  if (rdPtr == startPtr - 1'b1) begin
                    state     <= IDLE;
                    rdPhase   <= RD_SETUP;
                    Triggered <= 1'b0;
                    Done      <= 1'b1;
                  end else begin
                    rdPtr   <= rdPtr + 1'b1;
                    rdPhase <= RD_LOAD;
                  end
                end
              end
            end
          endcase
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
